// File: rtl/can_periph_select_ctrl.sv
// -----------------------------------------------------------------------------
// can_periph_select_ctrl
//
// Chip-select and handshake controller for the CAN peripheral window on the
// 68k bus. The window starting at BASE_ADDR is split into NUM_CH slots of
// CH_SPAN bytes each. An access that hits a slot raises that slot's enable
// and returns DTACK after WAIT_STATES clocks. An access inside the Select_H
// window that misses every slot is answered with a bus error.
//
// Ports:
//   Clk         system clock, all state on the rising edge
//   Reset_L     asynchronous active-low reset
//   Address     68k byte address
//   Select_H    upstream window select from the top-level decoder
//   AS_L        68k address strobe
//   UDS_L       upper data strobe
//   LDS_L       lower data strobe
//   Enable_H    one-hot channel enable (registered)
//   DtackOut_L  data-transfer acknowledge to the CPU (registered)
//   BErr_L      bus error to the CPU (registered)
//   Busy_H      high whenever the controller is not idle (registered)
// -----------------------------------------------------------------------------
module can_periph_select_ctrl #(
    parameter int          NUM_CH      = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0050_0000,
    parameter logic [31:0] CH_SPAN     = 32'h0000_0200,
    parameter logic [31:0] WIN_SIZE    = 32'h0001_0000,
    parameter int          WAIT_STATES = 2
) (
    input  logic              Clk,
    input  logic              Reset_L,
    input  logic [31:0]       Address,
    input  logic              Select_H,
    input  logic              AS_L,
    input  logic              UDS_L,
    input  logic              LDS_L,
    output logic [NUM_CH-1:0] Enable_H,
    output logic              DtackOut_L,
    output logic              BErr_L,
    output logic              Busy_H
);

    // CH_SPAN is a power of two, so the slot index is a plain right shift.
    localparam int          SPAN_SHIFT = $clog2(CH_SPAN);
    localparam logic [31:0] SLOT_BYTES = 32'(NUM_CH) * CH_SPAN;
    localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_BERR
    } state_t;

    state_t            state;
    logic [3:0]        wait_cnt;
    logic [31:0]       offset;
    logic [31:0]       slot;
    logic              hit;
    logic              start;
    logic [NUM_CH-1:0] slot_onehot;

    // Address decode. Subtraction wraps for addresses below BASE_ADDR, which
    // yields a huge offset and therefore a miss without any extra compare.
    always_comb begin
        offset      = Address - BASE_ADDR;
        slot        = offset >> SPAN_SHIFT;
        hit         = (offset < SLOT_BYTES);
        start       = Select_H && !AS_L && (!UDS_L || !LDS_L);
        slot_onehot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            slot_onehot[i] = hit && (slot == 32'(i));
        end
    end

    // Main controller. The slot is captured into Enable_H on the start edge,
    // so later changes of Address or the data strobes have no effect. Only
    // AS_L ends a cycle; leaving WAIT/ACK/BERR requires AS_L high, which keeps
    // a strobe held low across the return to IDLE from retriggering.
    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            Enable_H   <= '0;
            DtackOut_L <= 1'b1;
            BErr_L     <= 1'b1;
            Busy_H     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        Busy_H <= 1'b1;
                        if (hit) begin
                            Enable_H <= slot_onehot;
                            if (WAIT_STATES == 0) begin
                                state      <= ST_ACK;
                                DtackOut_L <= 1'b0;
                            end else begin
                                state    <= ST_WAIT;
                                wait_cnt <= WAIT_LOAD;
                            end
                        end else begin
                            state  <= ST_BERR;
                            BErr_L <= 1'b0;
                        end
                    end
                end

                // The counter holds the number of edges still to go before
                // DTACK; the edge that sees 1 is the one that asserts it.
                ST_WAIT: begin
                    if (AS_L) begin
                        state    <= ST_IDLE;
                        Enable_H <= '0;
                        wait_cnt <= '0;
                        Busy_H   <= 1'b0;
                    end else if (wait_cnt == 4'd1) begin
                        state      <= ST_ACK;
                        DtackOut_L <= 1'b0;
                        wait_cnt   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                ST_ACK: begin
                    if (AS_L) begin
                        state      <= ST_IDLE;
                        Enable_H   <= '0;
                        DtackOut_L <= 1'b1;
                        Busy_H     <= 1'b0;
                    end
                end

                ST_BERR: begin
                    if (AS_L) begin
                        state  <= ST_IDLE;
                        BErr_L <= 1'b1;
                        Busy_H <= 1'b0;
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    wait_cnt   <= '0;
                    Enable_H   <= '0;
                    DtackOut_L <= 1'b1;
                    BErr_L     <= 1'b1;
                    Busy_H     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_can_periph_select_ctrl.sv
// -----------------------------------------------------------------------------
// tb_can_periph_select_ctrl
//
// Directed bench for can_periph_select_ctrl. Three builds share one set of
// bus inputs: the default build (2 slots, 2 wait states), a zero-wait-state
// build, and a 4-slot build with 256-byte slots and 3 wait states. Inputs
// are driven and outputs sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_can_periph_select_ctrl;

    logic        clk = 1'b0;
    logic        reset_l;
    logic [31:0] address;
    logic        select_h;
    logic        as_l;
    logic        uds_l;
    logic        lds_l;

    logic [1:0]  enable_a;
    logic        dtack_a, berr_a, busy_a;
    logic [1:0]  enable_z;
    logic        dtack_z, berr_z, busy_z;
    logic [3:0]  enable_f;
    logic        dtack_f, berr_f, busy_f;

    int check_count = 0;
    int error_count = 0;

    // 100 MHz clock
    always #5 clk = ~clk;

    // Default build
    can_periph_select_ctrl dut_a (
        .Clk(clk), .Reset_L(reset_l), .Address(address), .Select_H(select_h),
        .AS_L(as_l), .UDS_L(uds_l), .LDS_L(lds_l),
        .Enable_H(enable_a), .DtackOut_L(dtack_a), .BErr_L(berr_a), .Busy_H(busy_a)
    );

    // Zero-wait-state build
    can_periph_select_ctrl #(.WAIT_STATES(0)) dut_z (
        .Clk(clk), .Reset_L(reset_l), .Address(address), .Select_H(select_h),
        .AS_L(as_l), .UDS_L(uds_l), .LDS_L(lds_l),
        .Enable_H(enable_z), .DtackOut_L(dtack_z), .BErr_L(berr_z), .Busy_H(busy_z)
    );

    // Four-slot build, 256-byte slots, 3 wait states
    can_periph_select_ctrl #(.NUM_CH(4), .CH_SPAN(32'h0000_0100), .WAIT_STATES(3)) dut_f (
        .Clk(clk), .Reset_L(reset_l), .Address(address), .Select_H(select_h),
        .AS_L(as_l), .UDS_L(uds_l), .LDS_L(lds_l),
        .Enable_H(enable_f), .DtackOut_L(dtack_f), .BErr_L(berr_f), .Busy_H(busy_f)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive all bus inputs at once
    task automatic applyStimulus(input logic [31:0] addr, input logic sel,
                                 input logic as_n, input logic uds_n, input logic lds_n);
        address  = addr;
        select_h = sel;
        as_l     = as_n;
        uds_l    = uds_n;
        lds_l    = lds_n;
    endtask

    // Advance one clock and settle 1 ns past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Return the bus to idle and let every build see AS_L high
    task automatic busIdle();
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        tick();
    endtask

    initial begin
        // Reset asserted with a start-looking bus
        reset_l = 1'b0;
        applyStimulus(32'h0050_0010, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("rst_enable",  32'(enable_a), 32'h0);
        checkOutput("rst_dtack",   32'(dtack_a),  32'h1);
        checkOutput("rst_berr",    32'(berr_a),   32'h1);
        checkOutput("rst_busy",    32'(busy_a),   32'h0);

        // Release reset with AS_L still low but Select_H low: no cycle
        select_h = 1'b0;
        reset_l  = 1'b1;
        tick();
        tick();
        checkOutput("norel_busy",   32'(busy_a),   32'h0);
        checkOutput("norel_enable", 32'(enable_a), 32'h0);
        busIdle();

        // Read 0x00500010 with UDS: slot 0, DTACK two edges later
        applyStimulus(32'h0050_0010, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("s0_enable_n",  32'(enable_a), 32'h1);
        checkOutput("s0_dtack_n",   32'(dtack_a),  32'h1);
        checkOutput("s0_busy_n",    32'(busy_a),   32'h1);
        checkOutput("z_s0_enable",  32'(enable_z), 32'h1);
        checkOutput("z_s0_dtack",   32'(dtack_z),  32'h0);
        checkOutput("f_s0_enable",  32'(enable_f), 32'h1);
        // Address moves into the error region after start: must be ignored
        address = 32'h0050_0400;
        tick();
        checkOutput("s0_dtack_n1",  32'(dtack_a),  32'h1);
        checkOutput("s0_enable_n1", 32'(enable_a), 32'h1);
        tick();
        checkOutput("s0_dtack_n2",  32'(dtack_a),  32'h0);
        checkOutput("s0_enable_n2", 32'(enable_a), 32'h1);
        checkOutput("s0_berr_n2",   32'(berr_a),   32'h1);
        as_l = 1'b1;
        tick();
        checkOutput("s0_end_enable", 32'(enable_a), 32'h0);
        checkOutput("s0_end_dtack",  32'(dtack_a),  32'h1);
        checkOutput("s0_end_busy",   32'(busy_a),   32'h0);
        busIdle();

        // 0x005003FE with LDS: top of slot 1; Select_H dropped mid-cycle
        applyStimulus(32'h0050_03FE, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("s1hi_enable", 32'(enable_a), 32'h2);
        select_h = 1'b0;
        tick();
        checkOutput("s1hi_dtack_n1", 32'(dtack_a), 32'h1);
        tick();
        checkOutput("s1hi_dtack_n2", 32'(dtack_a), 32'h0);
        busIdle();

        // 0x00500200: first byte of slot 1
        applyStimulus(32'h0050_0200, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("s1lo_enable", 32'(enable_a), 32'h2);
        tick();
        tick();
        checkOutput("s1lo_dtack_n2", 32'(dtack_a), 32'h0);
        busIdle();

        // 0x00500400: inside the window, past the last slot -> bus error
        applyStimulus(32'h0050_0400, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("berr_berr",   32'(berr_a),   32'h0);
        checkOutput("berr_enable", 32'(enable_a), 32'h0);
        checkOutput("berr_dtack",  32'(dtack_a),  32'h1);
        checkOutput("berr_busy",   32'(busy_a),   32'h1);
        checkOutput("f_berr_berr", 32'(berr_f),   32'h0);
        tick();
        checkOutput("berr_hold",   32'(berr_a),   32'h0);
        checkOutput("berr_hold_dtack", 32'(dtack_a), 32'h1);
        as_l = 1'b1;
        tick();
        checkOutput("berr_end",    32'(berr_a),   32'h1);
        checkOutput("berr_end_busy", 32'(busy_a), 32'h0);
        busIdle();

        // Address just below BASE_ADDR wraps to a huge offset -> bus error
        applyStimulus(32'h004F_FFFE, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("below_berr",   32'(berr_a),   32'h0);
        checkOutput("below_enable", 32'(enable_a), 32'h0);
        busIdle();

        // Zero-wait build at 0x00500000: enable and DTACK on the same edge
        applyStimulus(32'h0050_0000, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("z_base_enable", 32'(enable_z), 32'h1);
        checkOutput("z_base_dtack",  32'(dtack_z),  32'h0);
        busIdle();

        // 0x00500380: slot 3 of the 4-slot build, slot 1 of the default ones
        applyStimulus(32'h0050_0380, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("f_s3_enable", 32'(enable_f), 32'h8);
        checkOutput("a_380_enable", 32'(enable_a), 32'h2);
        checkOutput("z_380_enable", 32'(enable_z), 32'h2);
        checkOutput("z_380_dtack",  32'(dtack_z),  32'h0);
        busIdle();

        // 3-wait build: AS_L rises one cycle after start -> abort, no DTACK
        applyStimulus(32'h0050_0000, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("f_abort_enable_n", 32'(enable_f), 32'h1);
        checkOutput("f_abort_dtack_n",  32'(dtack_f),  32'h1);
        as_l = 1'b1;
        tick();
        checkOutput("f_abort_enable", 32'(enable_f), 32'h0);
        checkOutput("f_abort_busy",   32'(busy_f),   32'h0);
        checkOutput("f_abort_dtack",  32'(dtack_f),  32'h1);
        tick();
        tick();
        checkOutput("f_abort_dtack_late", 32'(dtack_f), 32'h1);
        busIdle();

        // Second access reaches ACK, then asynchronous reset between edges
        applyStimulus(32'h0050_0010, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        checkOutput("ack_dtack_pre", 32'(dtack_a), 32'h0);
        #2;
        reset_l = 1'b0;
        #1;
        checkOutput("arst_enable", 32'(enable_a), 32'h0);
        checkOutput("arst_dtack",  32'(dtack_a),  32'h1);
        checkOutput("arst_busy",   32'(busy_a),   32'h0);
        checkOutput("arst_berr",   32'(berr_a),   32'h1);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
